// File: rtl/ps2_pkg.sv
// Shared scancode constants, event width and parser state encoding for the
// PS/2 key tracker.
package ps2_pkg;

  localparam logic [7:0] SC_E0           = 8'hE0;
  localparam logic [7:0] SC_F0           = 8'hF0;
  localparam logic [7:0] SC_E1           = 8'hE1;
  localparam logic [7:0] SC_FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_FAKE_SHIFT_R = 8'h59;

  // Keyboard status/protocol bytes that never represent a key
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  localparam int EVT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } ps2_state_e;

  function automatic logic is_ignore(input logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_ERR_LO) || (b == SC_ERR_HI);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == SC_FAKE_SHIFT_L) || (b == SC_FAKE_SHIFT_R);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte-stream input and event-stream output bundle of the key tracker.
interface ps2_key_tracker_if
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) ();

  logic                          byte_valid;
  logic [7:0]                    byte_data;
  logic                          evt_valid;
  logic                          evt_ready;
  logic [EVT_W-1:0]              evt_data;
  logic [$clog2(FIFO_DEPTH):0]   evt_count;

  modport master (
    output byte_valid, byte_data, evt_ready,
    input  evt_valid, evt_data, evt_count
  );

  modport slave (
    input  byte_valid, byte_data, evt_ready,
    output evt_valid, evt_data, evt_count
  );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, otherwise it is reported as a drop.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             full;
  logic             pop_en;
  logic             wr_en;

  // Pointer MSB distinguishes wrap-around so full and empty never alias
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count  = wptr_q - rptr_q;
  assign pop_en = pop && !empty && !clr;
  assign wr_en  = push && !clr && (!full || pop_en);
  assign drop   = push && !clr && full && !pop_en;
  assign rdata  = empty ? '0 : mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_en)  wptr_d = wptr_q + (AW+1)'(1);
      if (pop_en) rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scancode parser with a 512-bit held-key bitmap, a watched-key vector
// and a buffered make/break event stream with sticky overflow.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                 NKEYS       = 11,
  parameter logic [9*NKEYS-1:0] KEYMAP      = {9'h025, 9'h026, 9'h01E, 9'h016,
                                               9'h029, 9'h05A, 9'h024, 9'h023,
                                               9'h01B, 9'h01C, 9'h01D},
  parameter int                 FIFO_DEPTH  = 8,
  parameter int                 TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_key_tracker_if.slave  bus,
  input  logic              clr,
  output logic [NKEYS-1:0]  held,
  output logic              any_held,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int             TW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]  TCNT_MAX = TW'(TIMEOUT_CYC - 1);

  ps2_state_e        state_q, state_d;
  logic [2:0]        skip_q, skip_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [511:0]      bitmap_q, bitmap_d;
  logic [NKEYS-1:0]  held_q, held_d;
  logic              any_q, any_d;
  logic              ovf_q, ovf_d;

  logic              kev, kbrk, kext;
  logic [8:0]        kidx;
  logic              push;
  logic              fifo_empty;
  logic              fifo_drop;
  logic [EVT_W-1:0]  fifo_wdata;

  // Parser: only byte strobes advance it; a stalled prefix times out to IDLE
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tcnt_d  = tcnt_q;
    kev     = 1'b0;
    kbrk    = 1'b0;
    kext    = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      skip_d  = '0;
      tcnt_d  = '0;
    end else if (bus.byte_valid) begin
      tcnt_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.byte_data == SC_E0) begin
            state_d = ST_EXT;
          end else if (bus.byte_data == SC_F0) begin
            state_d = ST_BRK;
          end else if (bus.byte_data == SC_E1) begin
            state_d = ST_SKIP;
            skip_d  = 3'd7;
          end else if (!is_ignore(bus.byte_data)) begin
            kev = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.byte_data == SC_F0) begin
            state_d = ST_EXTBRK;
          end else if (bus.byte_data == SC_E0) begin
            state_d = ST_EXT;
          end else if (is_fake_shift(bus.byte_data)) begin
            state_d = ST_IDLE;
          end else begin
            kev     = 1'b1;
            kext    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          kev     = 1'b1;
          kbrk    = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXTBRK: begin
          if (!is_fake_shift(bus.byte_data)) begin
            kev  = 1'b1;
            kext = 1'b1;
            kbrk = 1'b1;
          end
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_q <= 3'd1) begin
            skip_d  = '0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tcnt_q == TCNT_MAX) begin
        state_d = ST_IDLE;
        skip_d  = '0;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  // A make of a held key or a break of a released key changes nothing
  always_comb begin
    kidx     = {kext, bus.byte_data};
    bitmap_d = bitmap_q;
    push     = 1'b0;
    if (clr) begin
      bitmap_d = '0;
    end else if (kev && (kbrk == bitmap_q[kidx])) begin
      bitmap_d[kidx] = ~kbrk;
      push           = 1'b1;
    end
  end

  always_comb begin
    held_d = '0;
    any_d  = 1'b0;
    if (!clr) begin
      for (int i = 0; i < NKEYS; i++) begin
        held_d[i] = bitmap_q[KEYMAP[9*i +: 9]];
      end
      any_d = |bitmap_q;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (fifo_drop)         ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      skip_q   <= '0;
      tcnt_q   <= '0;
      bitmap_q <= '0;
      held_q   <= '0;
      any_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      tcnt_q   <= tcnt_d;
      bitmap_q <= bitmap_d;
      held_q   <= held_d;
      any_q    <= any_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fifo_wdata = {kbrk, kext, bus.byte_data};

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (bus.evt_ready),
    .wdata (fifo_wdata),
    .rdata (bus.evt_data),
    .empty (fifo_empty),
    .count (bus.evt_count),
    .drop  (fifo_drop)
  );

  assign bus.evt_valid = !fifo_empty;
  assign held          = held_q;
  assign any_held      = any_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a byte-level reference model predicts
// events, bitmap and overflow; a negedge monitor checks every popped event.
module tb_ps2_key_tracker;
  import ps2_pkg::*;

  localparam int NK    = 11;
  localparam int DEPTH = 8;
  localparam int TOUT  = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          overflow_clr = 1'b0;
  logic [NK-1:0] held;
  logic          any_held;
  logic          overflow;

  ps2_key_tracker_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_key_tracker #(
    .NKEYS       (NK),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clr          (clr),
    .held         (held),
    .any_held     (any_held),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  // Reference state: which of the 512 keys are down, pending prefix flags
  bit          m_bm [512];
  bit          m_ext, m_brk, m_ovf;
  int          m_skip, idle_gap;
  bit          pop_now, dropped;
  logic [9:0]  exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          keymap_tb [NK] = '{'h01D, 'h01C, 'h01B, 'h023, 'h024, 'h05A,
                                  'h029, 'h016, 'h01E, 'h026, 'h025};
  logic [7:0]  pool [20] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA, 8'hFA,
                             8'h00, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B,
                             8'h74, 8'h72, 8'h29, 8'h5A, 8'h16, 8'h1E};
  logic [7:0]  fill [9] = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                            8'h3D, 8'h3E};
  logic [7:0]  pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14,
                                 8'hF0, 8'h77};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL evt_unexpected: got %03h required none", bus.evt_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (bus.evt_data !== e) begin
          n_bad++;
          $display("FAIL evt_data: got %03h required %03h", bus.evt_data, e);
        end
      end
    end
  end

  function automatic logic [NK-1:0] exp_held();
    logic [NK-1:0] r;
    for (int i = 0; i < NK; i++) r[i] = m_bm[keymap_tb[i]];
    return r;
  endfunction

  function automatic logic exp_any();
    for (int i = 0; i < 512; i++) if (m_bm[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 512; i++) m_bm[i] = 1'b0;
    m_ext = 0; m_brk = 0; m_skip = 0; idle_gap = 0;
    exp_q.delete();
  endtask

  task automatic key_event(input bit ext, input bit brk, input logic [7:0] code);
    int idx;
    idx = (ext ? 256 : 0) + int'(code);
    if (!brk && m_bm[idx]) return;
    if (brk && !m_bm[idx]) return;
    m_bm[idx] = !brk;
    if (exp_q.size() < DEPTH || pop_now) exp_q.push_back({brk, ext, code});
    else dropped = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (idle_gap >= TOUT) begin
      m_ext = 0; m_brk = 0; m_skip = 0;
    end
    idle_gap = 0;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0 && !m_brk) begin
      m_ext = 1;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1;
    end else if (b == 8'hE1 && !m_ext && !m_brk) begin
      m_skip = 7;
    end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
      m_ext = 0; m_brk = 0;
    end else if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                                      b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
      // status byte, nothing to do
    end else begin
      key_event(m_ext, m_brk, b);
      m_ext = 0; m_brk = 0;
    end
  endtask

  // One clock: apply inputs at posedge+1, predict this edge, advance
  task automatic cycle(input bit bv, input logic [7:0] b);
    bus.byte_valid = bv;
    bus.byte_data  = b;
    pop_now = bus.evt_ready && (exp_q.size() > 0);
    dropped = 1'b0;
    if (clr) model_reset();
    else if (bv) model_byte(b);
    else idle_gap++;
    if (dropped) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    clr = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_held"}, 32'(held), 32'(exp_held()));
    chk({tag, "_any_held"}, 32'(any_held), 32'(exp_any()));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic drain(input string tag);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle(1);
    chk({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_evt_valid_empty"}, 32'(bus.evt_valid), 32'd0);
  endtask

  initial begin
    int burst;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.evt_ready  = 1'b0;
    m_ovf = 1'b0;
    burst = 0;
    model_reset();

    #12;
    chk("rst_held", 32'(held), 32'd0);
    chk("rst_any_held", 32'(any_held), 32'd0);
    chk("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst_evt_data", 32'(bus.evt_data), 32'd0);
    chk("rst_evt_count", 32'(bus.evt_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // make/break of W with latency checks
    send(8'h1D);
    chk("t1_evt_valid_k1", 32'(bus.evt_valid), 32'd1);
    chk("t1_evt_count", 32'(bus.evt_count), 32'd1);
    chk("t1_held0_k1", 32'(held[0]), 32'd0);
    idle(1);
    chk("t1_held0_k2", 32'(held[0]), 32'd1);
    send(8'hF0); send(8'h1D);
    chk("t1_held0_brk_k1", 32'(held[0]), 32'd1);
    idle(1);
    check_state("t1");
    drain("t1");

    // typematic repeats of A
    send(8'h1C); send(8'h1C); idle(1);
    chk("t2_held1_rep", 32'(held[1]), 32'd1);
    send(8'h1C); idle(1);
    check_state("t2_rep");
    send(8'hF0); send(8'h1C); idle(1);
    check_state("t2_rel");
    drain("t2");

    // extended key, fake shift
    send(8'hE0); send(8'h75); idle(1);
    check_state("t3_mid");
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12); idle(1);
    check_state("t3_end");
    drain("t3");

    // FIFO overflow, full with simultaneous pop, overflow clear priority
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(fill[i]);
    idle(1);
    chk("t4_count_full", 32'(bus.evt_count), 32'(DEPTH));
    check_state("t4_full");
    bus.evt_ready = 1'b1;
    send(8'h46);
    bus.evt_ready = 1'b0;
    chk("t4_count_pushpop", 32'(bus.evt_count), 32'(exp_q.size()));
    overflow_clr = 1'b1;
    send(8'h4E);
    chk("t4_ovf_set_wins", 32'(overflow), 32'(m_ovf));
    overflow_clr = 1'b1;
    idle(1);
    check_state("t4_clr");
    drain("t4");

    // Pause sequence then a normal key
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    send(8'h29); idle(1);
    check_state("t5");
    drain("t5");

    // prefix timeout, both sides of the boundary
    send(8'h1D);
    send(8'hF0); idle(TOUT - 1); send(8'h1D);
    send(8'hF0); idle(TOUT);     send(8'h1D);
    idle(1);
    check_state("t6");
    drain("t6");

    // synchronous clear with queued events and a pending prefix
    bus.evt_ready = 1'b0;
    send(8'h1B); send(8'h23); send(8'h24); send(8'hE0);
    chk("t7_count_before", 32'(bus.evt_count), 32'(exp_q.size()));
    clr = 1'b1;
    idle(1);
    chk("t7_held", 32'(held), 32'd0);
    chk("t7_any_held", 32'(any_held), 32'd0);
    chk("t7_evt_valid", 32'(bus.evt_valid), 32'd0);
    chk("t7_evt_count", 32'(bus.evt_count), 32'd0);
    chk("t7_overflow", 32'(overflow), 32'(m_ovf));
    send(8'h75);
    drain("t7");

    // randomized byte stream with back-pressure
    for (int n = 0; n < 400; n++) begin
      if (burst > 0) begin
        bus.evt_ready = 1'b0;
        burst--;
      end else begin
        bus.evt_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 40) == 0) burst = $urandom_range(5, 20);
      end
      overflow_clr = ($urandom_range(0, 15) == 0);
      send(pool[$urandom_range(0, 19)]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain("t8");
    idle(1);
    check_state("t8");

    // asynchronous reset in the middle of an extended sequence
    bus.evt_ready = 1'b0;
    send(8'h4D); send(8'hE0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t9_held", 32'(held), 32'd0);
    chk("t9_any_held", 32'(any_held), 32'd0);
    chk("t9_evt_valid", 32'(bus.evt_valid), 32'd0);
    chk("t9_evt_data", 32'(bus.evt_data), 32'd0);
    chk("t9_evt_count", 32'(bus.evt_count), 32'd0);
    chk("t9_overflow", 32'(overflow), 32'd0);
    model_reset();
    m_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h75);
    drain("t9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Consumes the decoded PS/2 byte stream (one byte per strobe) from the PS/2 receiver.
- Parses make, break (F0), extended (E0) and Pause (E1) sequences.
- Keeps a 512-entry held-key bitmap: 256 normal plus 256 extended codes.
- Exposes a parametrised vector of watched keys for LEDs and game logic, and a buffered make/break event stream for the UART/host path.
- Generalises the fixed 11-LED tracker: configurable key map, extended keys, typematic filtering, event FIFO with overflow reporting.

Parameters:
- NKEYS, 11, number of watched keys and the width of held.
- KEYMAP, {9'h025,9'h026,9'h01E,9'h016,9'h029,9'h05A,9'h024,9'h023,9'h01B,9'h01C,9'h01D}, packed 9*NKEYS. Entry i = {ext,code} drives held[i]. Entry 0 is the LSB (W,A,S,D,E,Enter,Space,1,2,3,4).
- FIFO_DEPTH, 8, event FIFO entries. Must be a power of 2, at least 2.
- TIMEOUT_CYC, 2000000, idle cycles after which a partial prefix sequence is abandoned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- byte_valid  in  1  one-cycle strobe; byte_data is valid
- byte_data  in  8  received scancode byte
- clr  in  1  synchronous clear: bitmap, parser and FIFO
- held  out  NKEYS  held[i]=1 while key KEYMAP[i] is down
- any_held  out  1  OR of the full 512-bit bitmap
- evt_valid  out  1  FIFO not empty
- evt_ready  in  1  consumer pops the head when evt_valid && evt_ready
- evt_data  out  10  {brk, ext, code[7:0]} at the FIFO head
- evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: an event was dropped
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset (rst_n low, async):
  - bitmap, parser and FIFO cleared
  - held=0, any_held=0, evt_valid=0, evt_data=0, evt_count=0, overflow=0
- Parser FSM, advances only on byte_valid:
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - E1 -> SKIP, with skip counter=7
    - AA/FA/EE/FE/00/FF are ignored
    - any other byte: key event (ext=0, brk=0), stay in IDLE
  - EXT:
    - F0 -> EXTBRK
    - E0 stays in EXT
    - 12 or 59 (fake shift) -> IDLE, no event
    - other byte: key event (ext=1, brk=0) -> IDLE
  - BRK: any byte gives key event (ext=0, brk=1) -> IDLE.
  - EXTBRK:
    - 12 or 59 -> IDLE, no event
    - other byte: key event (ext=1, brk=1) -> IDLE
  - SKIP: decrement the counter on each byte; IDLE after the 7th byte. No events; Pause is not tracked.
- Timeout: in any non-IDLE state, a cycle counter increments and resets on every byte_valid. When it reaches TIMEOUT_CYC-1 the FSM returns to IDLE with no event.
- Key event handling, same edge as the final byte:
  - index = {ext, code}
  - make of a key that is already held: typematic repeat, no change, no push
  - break of a key that is not held: no change, no push
  - otherwise: write the bitmap bit (1 for make, 0 for break) and push {brk, ext, code}
- Latency, final byte sampled at edge k:
  - bitmap and FIFO written at edge k
  - evt_valid high in cycle k+1 if the FIFO was empty; no bypass
  - held and any_held registered, updating at edge k+1
- FIFO:
  - full, push, no pop: event dropped, bitmap still updated, overflow set
  - full, push and pop in the same cycle: both occur, no drop
  - evt_ready while evt_valid=0 is ignored
  - evt_data holds the head value until popped
- overflow_clr clears overflow. If a drop occurs in the same cycle, set wins.
- clr:
  - takes priority over byte_valid and the FIFO push/pop
  - next cycle: bitmap=0, FSM=IDLE, FIFO empty
  - no break events are generated
  - overflow is unaffected
- Width rules: evt_count is in 0..FIFO_DEPTH. FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, with the MSB used for full/empty.

Decomposition:
- Package ps2_pkg:
  - constants SC_E0=8'hE0, SC_F0=8'hF0, SC_E1=8'hE1, SC_FAKE_SHIFT_L=8'h12, SC_FAKE_SHIFT_R=8'h59
  - ignore codes AA/FA/EE/FE/00/FF
  - event field width EVT_W=10
  - parser state encoding IDLE/EXT/BRK/EXTBRK/SKIP
- Sub-module ps2_evt_fifo: synchronous FIFO (DEPTH, WIDTH) with push/pop/count and a full-with-pop rule. The tracker instantiates it once.

Test Plan:
- Bytes 1D, then F0 1D:
  - held[0] rises 2 cycles after the 1D strobe and falls after the second 1D
  - events 01D then 21D
- 1C 1C 1C (typematic), then F0 1C: exactly 2 events (01C, 21C); held[1] stays high throughout the repeats.
- E0 75, then E0 F0 75:
  - events 175, 375
  - any_held=1 between the two sequences
  - no held bit set with the default KEYMAP
  - E0 12 produces no event
- 9 distinct makes with evt_ready=0: evt_count saturates at 8 and overflow=1, but all 9 bitmap bits are set. Then:
  - pop one with a simultaneous 10th make: count stays 8, no new drop
  - overflow_clr -> overflow=0
- E1 14 77 E1 F0 14 F0 77: no events, FSM back in IDLE; a following 29 gives event 029.
- Reset and clear checks:
  - F0 then 2 000 000 idle cycles, then 1D: event 01D (make, not break)
  - clr asserted with keys held and 3 events queued: held=0, evt_valid=0 next cycle
  - rst_n pulsed low mid-sequence (after E0): all outputs 0 asynchronously
